// File: rtl/lcd12864_text_ctrl_if.sv
// Host-side write port and LCD-side parallel bus of the 12864 text controller.
// The controller uses the slave modport; a host or bench uses the master modport.
interface lcd12864_text_ctrl_if;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       refresh;
   logic       rs;
   logic       rw;
   logic       en;
   logic [7:0] dat;
   logic       busy;
   logic       init_done;

   modport master (
      output wr_en, wr_addr, wr_data, refresh,
      input  rs, rw, en, dat, busy, init_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, refresh,
      output rs, rw, en, dat, busy, init_done
   );
endinterface

// File: rtl/lcd12864_text_ctrl.sv
// Text-mode controller for an ST7920-style 12864 LCD: a 4x16 character buffer is
// streamed to the panel over the 8-bit parallel bus after a power-up init sequence.
module lcd12864_text_ctrl #(
   parameter int PHASE_CYC    = 25,
   parameter int INIT_WAIT    = 2000000,
   parameter int CMD_WAIT     = 4000,
   parameter int CLR_WAIT     = 80000,
   parameter int AUTO_REFRESH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   lcd12864_text_ctrl_if.slave  bus
);

   localparam int MAX_A = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
   localparam int MAX_B = (CMD_WAIT > PHASE_CYC) ? CMD_WAIT : PHASE_CYC;
   localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_W + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t PWR_LAST   = cnt_t'(INIT_WAIT - 1);
   localparam cnt_t PHASE_LAST = cnt_t'(PHASE_CYC - 1);
   localparam cnt_t CMD_LAST   = cnt_t'(CMD_WAIT - 1);
   localparam cnt_t CLR_LAST   = cnt_t'(CLR_WAIT - 1);

   typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR, S_DATA} state_e;
   typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_HOLD, PH_WAIT} phase_e;

   state_e     state_q, state_d;
   phase_e     phase_q, phase_d;
   cnt_t       cnt_q, cnt_d;
   logic [1:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic [2:0] step_q, step_d;
   logic       dirty_q, dirty_d;
   logic       init_done_q, init_done_d;
   logic       rs_q, rs_d;
   logic       en_q, en_d;
   logic [7:0] dat_q, dat_d;
   logic [7:0] mem_q [64];

   logic       load, load_rs, byte_done, end_seq, frame_go;
   logic [7:0] load_dat;
   cnt_t       wait_last;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1: init_cmd = 8'h30;
         3'd2:       init_cmd = 8'h0C;
         3'd3:       init_cmd = 8'h01;
         default:    init_cmd = 8'h06;
      endcase
   endfunction

   // DDRAM start address of each text row on the 12864 (rows 2/3 interleave).
   function automatic logic [7:0] row_cmd(input logic [1:0] row);
      case (row)
         2'd0:    row_cmd = 8'h80;
         2'd1:    row_cmd = 8'h90;
         2'd2:    row_cmd = 8'h88;
         default: row_cmd = 8'h98;
      endcase
   endfunction

   // NOTE: character RAM has no reset; contents are undefined until the host writes them.
   always_ff @(posedge clk) begin
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
   end

   always_comb begin
      // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      step_d      = step_q;
      dirty_d     = dirty_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      en_d        = en_q;
      dat_d       = dat_q;
      load        = 1'b0;
      load_rs     = 1'b0;
      load_dat    = 8'h00;
      byte_done   = 1'b0;
      end_seq     = 1'b0;
      frame_go    = dirty_q || (AUTO_REFRESH != 0);
      wait_last   = (!rs_q && dat_q == 8'h01) ? CLR_LAST : CMD_LAST;

      case (state_q)
         S_PWR: begin
            if (cnt_q == PWR_LAST) begin
               state_d  = S_INIT;
               step_d   = 3'd0;
               load     = 1'b1;
               load_dat = init_cmd(3'd0);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (frame_go) begin
               state_d  = S_ADDR;
               row_d    = 2'd0;
               dirty_d  = 1'b0;
               load     = 1'b1;
               load_dat = row_cmd(2'd0);
            end
         end
         default: begin
            case (phase_q)
               PH_SETUP: if (cnt_q == PHASE_LAST) begin
                  phase_d = PH_HIGH; cnt_d = '0; en_d = 1'b1;
               end else cnt_d = cnt_q + 1'b1;
               PH_HIGH: if (cnt_q == PHASE_LAST) begin
                  phase_d = PH_HOLD; cnt_d = '0; en_d = 1'b0;
               end else cnt_d = cnt_q + 1'b1;
               PH_HOLD: if (cnt_q == PHASE_LAST) begin
                  phase_d = PH_WAIT; cnt_d = '0;
               end else cnt_d = cnt_q + 1'b1;
               default: if (cnt_q == wait_last) byte_done = 1'b1;
                        else cnt_d = cnt_q + 1'b1;
            endcase
         end
      endcase

      if (byte_done) begin
         case (state_q)
            S_INIT: begin
               if (step_q == 3'd4) begin
                  init_done_d = 1'b1;
                  end_seq     = 1'b1;
               end else begin
                  step_d   = step_q + 3'd1;
                  load     = 1'b1;
                  load_dat = init_cmd(step_q + 3'd1);
               end
            end
            S_ADDR: begin
               state_d  = S_DATA;
               col_d    = 4'd0;
               load     = 1'b1;
               load_rs  = 1'b1;
               load_dat = mem_q[{row_q, 4'd0}];
            end
            default: begin
               if (col_q != 4'd15) begin
                  col_d    = col_q + 4'd1;
                  load     = 1'b1;
                  load_rs  = 1'b1;
                  load_dat = mem_q[{row_q, col_q + 4'd1}];
               end else if (row_q != 2'd3) begin
                  state_d  = S_ADDR;
                  row_d    = row_q + 2'd1;
                  load     = 1'b1;
                  load_dat = row_cmd(row_q + 2'd1);
               end else begin
                  end_seq = 1'b1;
               end
            end
         endcase
      end

      // A pending frame starts straight away so busy stays high between frames.
      if (end_seq) begin
         if (frame_go) begin
            state_d  = S_ADDR;
            row_d    = 2'd0;
            dirty_d  = 1'b0;
            load     = 1'b1;
            load_dat = row_cmd(2'd0);
         end else begin
            state_d = S_IDLE;
         end
      end

      if (load) begin
         rs_d    = load_rs;
         dat_d   = load_dat;
         phase_d = PH_SETUP;
         cnt_d   = '0;
      end

      if (bus.wr_en || bus.refresh) dirty_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_PWR;
         phase_q     <= PH_SETUP;
         cnt_q       <= '0;
         row_q       <= 2'd0;
         col_q       <= 4'd0;
         step_q      <= 3'd0;
         dirty_q     <= 1'b0;
         init_done_q <= 1'b0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         dat_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         step_q      <= step_d;
         dirty_q     <= dirty_d;
         init_done_q <= init_done_d;
         rs_q        <= rs_d;
         en_q        <= en_d;
         dat_q       <= dat_d;
      end
   end

   assign bus.rs        = rs_q;
   assign bus.rw        = 1'b0;
   assign bus.en        = en_q;
   assign bus.dat       = dat_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.init_done = init_done_q;

endmodule
